// File: rtl/mdu_sequencer_if.sv
// Request/result bundle between the instruction decoder and the multiply/divide sequencer.
// Carries the op request and operands, HiLo read-back, stall, and the HiLo write port.
// The decoder holds Start until Stall drops; the sequencer reports completion with a one-cycle HiLoEn.
interface mdu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                 Start;
    logic [2:0]           Op;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   HiLoRead;
    logic                 Stall;
    logic                 HiLoEn;
    logic [2*WIDTH-1:0]   HiLoWrite;
    logic                 DivZero;

    // Decoder / pipeline side
    modport master (
        output Start, Op, A, B, HiLoRead,
        input  Stall, HiLoEn, HiLoWrite, DivZero
    );

    // Sequencer side
    modport slave (
        input  Start, Op, A, B, HiLoRead,
        output Stall, HiLoEn, HiLoWrite, DivZero
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative shift-add multiply / restoring divide for HiLo (MULT/MULTU/DIV/DIVU/MADD/MSUB).
// Latency: issue cycle + 33 edges; HiLoEn pulses for one cycle 34 cycles after the issue cycle.
// Backpressure: Stall is high from the issue cycle through FIX; new Starts are only taken in IDLE.
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    mdu_sequencer_if.slave bus
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_div_op(input logic [2:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] o);
        return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
    endfunction

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;        // raw dividend, returned in Hi on divide-by-zero
    logic [WIDTH-1:0]     mcand;      // multiplicand magnitude, or divisor magnitude
    logic [2*WIDTH-1:0]   prod;       // {acc, multiplier} for multiply, {remainder, quotient} for divide
    logic [2*WIDTH-1:0]   hilo_q;
    logic                 sign_a;
    logic                 sign_b;
    logic                 hilo_en;
    logic [2*WIDTH-1:0]   hilo_write;
    logic                 div_zero;

    logic                 op_valid;
    logic                 accept;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH:0]       div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   div_next;

    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;
    logic [2*WIDTH-1:0]   fix_res;
    logic                 fix_dz;

    assign op_valid = (bus.Op <= OP_MSUB);
    assign accept   = (state == IDLE) && bus.Start && op_valid;

    // PC hold is combinational so the issue cycle itself is already stalled
    assign bus.Stall     = accept || (state == RUN) || (state == FIX);
    assign bus.HiLoEn    = hilo_en;
    assign bus.HiLoWrite = hilo_write;
    assign bus.DivZero   = div_zero;

    // Operand magnitudes and sign flags for the request being issued
    always_comb begin
        a_neg = is_signed_op(bus.Op) && bus.A[WIDTH-1];
        b_neg = is_signed_op(bus.Op) && bus.B[WIDTH-1];
        mag_a = a_neg ? -bus.A : bus.A;
        mag_b = b_neg ? -bus.B : bus.B;
    end

    // One shift-add multiply step and one restoring divide step on the shared product register
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};
        div_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_diff = div_sh - {1'b0, mcand};
        div_ok   = (div_sh >= {1'b0, mcand});
        // remainder stays below the divisor, so the kept value always fits WIDTH bits
        div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), prod[WIDTH-2:0], div_ok};
    end

    // Sign correction and final HiLo value, evaluated in FIX
    always_comb begin
        prod_s  = (sign_a ^ sign_b) ? -prod : prod;
        quo_s   = (sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_s   = sign_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        fix_dz  = is_div_op(op_q) && (mcand == '0);
        fix_res = prod_s;
        case (op_q)
            OP_MADD: fix_res = hilo_q + prod_s;
            OP_MSUB: fix_res = hilo_q - prod_s;
            OP_DIV, OP_DIVU: begin
                if (fix_dz) fix_res = {a_q, {WIDTH{1'b1}}};
                else        fix_res = {rem_s, quo_s};
            end
            default: fix_res = prod_s;
        endcase
    end

    // Sequencer FSM: capture on issue, iterate ITER times, correct signs, pulse the HiLo write
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            mcand      <= '0;
            prod       <= '0;
            hilo_q     <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            hilo_en    <= 1'b0;
            hilo_write <= '0;
            div_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hilo_en <= 1'b0;
                    if (accept) begin
                        op_q     <= bus.Op;
                        a_q      <= bus.A;
                        hilo_q   <= bus.HiLoRead;
                        sign_a   <= a_neg;
                        sign_b   <= b_neg;
                        mcand    <= is_div_op(bus.Op) ? mag_b : mag_a;
                        prod     <= {{WIDTH{1'b0}}, (is_div_op(bus.Op) ? mag_a : mag_b)};
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    prod <= is_div_op(op_q) ? div_next : mul_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    hilo_write <= fix_res;
                    hilo_en    <= 1'b1;
                    if (fix_dz) div_zero <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    // DONE: the write pulse lasts exactly this cycle; Start is not looked at here
                    hilo_en <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: scoreboarded HiLo results, latency/stall timing, abort and invalid op.
// Expected values come from spec constants or a behavioural arithmetic model.
// Each op waits for HiLoEn with a bounded cycle budget.
module tb_mdu_sequencer;
    logic Clk;
    logic Rst;

    mdu_sequencer_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(.WIDTH(32), .ITER(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    logic [64:0] sb_q[$];   // {DivZero, HiLoWrite}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: native SV arithmetic, not the iterative algorithm
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        longint sp;
        logic [63:0] up;
        int q;
        int r;
        logic [64:0] res;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'b0, a} * {32'b0, b};
        res = '0;
        case (op)
            3'd0: res = {1'b0, sp};
            3'd1: res = {1'b0, up};
            3'd4: res = {1'b0, h + sp};
            3'd5: res = {1'b0, h - sp};
            3'd2, 3'd3: begin
                if (b == 32'd0) res = {1'b1, a, 32'hFFFF_FFFF};
                else if (op == 3'd2) begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    res = {1'b0, r, q};
                end else res = {1'b0, a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Issue one op, scramble inputs after acceptance, then wait for and score the HiLo write
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] h, input logic [64:0] exp);
        int n;
        int stall_cnt;
        logic [64:0] e;
        sb_q.push_back(exp);
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b; bus.HiLoRead = h;
        #1 chk({tag, "_issue_stall"}, 64'(bus.Stall), 64'd1);
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.Op = 3'($urandom_range(0, 7));
        bus.A = $urandom; bus.B = $urandom; bus.HiLoRead = {$urandom, $urandom};
        chk({tag, "_dz_clear"}, 64'(bus.DivZero), 64'd0);
        n = 1;
        stall_cnt = 0;
        while (!bus.HiLoEn && n < 100) begin
            if (bus.Stall) stall_cnt++;
            @(negedge Clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd34);
        chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd33);
        chk({tag, "_done_stall"}, 64'(bus.Stall), 64'd0);
        e = sb_q.pop_front();
        chk({tag, "_hilo"}, bus.HiLoWrite, e[63:0]);
        chk({tag, "_divzero"}, 64'(bus.DivZero), 64'(e[64]));
        @(negedge Clk);
        chk({tag, "_pulse_once"}, 64'(bus.HiLoEn), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [2:0] rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rh;
        Rst = 1'b0;
        bus.Start = 1'b0; bus.Op = 3'd0; bus.A = '0; bus.B = '0; bus.HiLoRead = '0;
        #12;
        chk("rst_stall", 64'(bus.Stall), 64'd0);
        chk("rst_hiloen", 64'(bus.HiLoEn), 64'd0);
        chk("rst_hilowrite", bus.HiLoWrite, 64'd0);
        chk("rst_divzero", 64'(bus.DivZero), 64'd0);
        @(negedge Clk);
        Rst = 1'b1;

        run_op("mult_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 64'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, {1'b0, 64'hFFFF_FFFE_0000_0001});
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        run_op("divu", 3'd3, 32'd100, 32'd7, 64'd0, {1'b0, 64'h0000_0002_0000_000E});
        run_op("divu_zero", 3'd3, 32'h1234_5678, 32'd0, 64'd0, {1'b1, 64'h1234_5678_FFFF_FFFF});
        chk("divzero_sticky", 64'(bus.DivZero), 64'd1);
        run_op("mult_after_dz", 3'd0, 32'h8000_0000, 32'd3, 64'd0,
               model(3'd0, 32'h8000_0000, 32'd3, 64'd0));
        run_op("madd", 3'd4, 32'd3, 32'd4, 64'h0000_0000_0000_0010, {1'b0, 64'h0000_0000_0000_001C});
        run_op("msub", 3'd5, 32'd3, 32'd4, 64'h0000_0000_0000_0010, {1'b0, 64'h0000_0000_0000_0004});

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = (i == 2) ? 32'hFFFF_FFF3 : $urandom;
            if (i == 3) ra = 32'hFFFF_FF00;
            rh = {$urandom, $urandom};
            run_op("rand", rop, ra, rb, rh, model(rop, ra, rb, rh));
        end

        // Abort a MULT in the middle of its iterations
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 3'd0; bus.A = 32'd5; bus.B = 32'd9;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (10) @(negedge Clk);
        chk("abort_running", 64'(bus.Stall), 64'd1);
        #2 Rst = 1'b0;
        #1;
        chk("abort_stall", 64'(bus.Stall), 64'd0);
        chk("abort_hiloen", 64'(bus.HiLoEn), 64'd0);
        chk("abort_hilowrite", bus.HiLoWrite, 64'd0);
        @(negedge Clk);
        Rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.HiLoEn || bus.Stall) pulses++;
        end
        chk("abort_no_write", 64'(pulses), 64'd0);

        // Invalid op must be ignored entirely
        bus.Start = 1'b1; bus.Op = 3'b111; bus.A = 32'd2; bus.B = 32'd2;
        #1 chk("invalid_issue_stall", 64'(bus.Stall), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (i == 3) bus.Start = 1'b0;
            if (bus.HiLoEn || bus.Stall) pulses++;
        end
        chk("invalid_idle", 64'(pulses), 64'd0);

        run_op("mult_final", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, {1'b0, 64'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
